// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: widths, queued write entry, FSM states.
package rf_arb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              kill;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Queue of buffered B-side register writes with per-entry kill-by-register match
// and a mask of registers that still have a live queued write.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [REG_AW-1:0]         push_wr,
  input  logic [DATA_W-1:0]         push_wd,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [REG_AW-1:0]         kill_wr,
  output logic [REG_AW-1:0]         head_wr,
  output logic [DATA_W-1:0]         head_wd,
  output logic                      head_kill,
  output logic                      full,
  output logic                      empty,
  output logic                      occupied_next,
  output logic [(1<<REG_AW)-1:0]    pend_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Only already-queued entries are squashed; the slot being written this cycle is not yet valid.
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && valid[i] && mem[i].wr == kill_wr) mem[i].kill <= 1'b1;
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr]   <= '{wr: push_wr, wd: push_wd, kill: 1'b0};
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_wr       = mem[rd_ptr].wr;
  assign head_wd       = mem[rd_ptr].wd;
  assign head_kill     = mem[rd_ptr].kill;
  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign occupied_next = push || (count > CW'(pop));

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && !mem[i].kill) pend_mask[mem[i].wr] = 1'b1;
    pend_mask[0] = 1'b0;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage (A) has priority, buffered B results drain when A is idle,
// and a starvation guard stalls WB for one cycle to force a drain. Optional stats via RF_ARB_STATS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
`ifdef RF_ARB_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wr,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wr,
  input  logic [31:0] b_wd,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic        wb_stall,
  output logic [31:0] pend_mask,
  output logic        err_drop,
  output logic [1:0]  dbg_state
`ifdef RF_ARB_STATS_EN
  , output logic [CNT_W-1:0] stat_bgrant,
  output logic [CNT_W-1:0] stat_stall
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  logic [SW-1:0]     starve_cnt;
  logic              a_req, in_force, a_grant, b_grant, push;
  logic              full, empty, occupied_next, head_kill;
  logic [REG_AW-1:0] head_wr;
  logic [DATA_W-1:0] head_wd;

  // Valid/ready on B: a result transfers in any cycle where b_valid && b_ready; b_ready depends only
  // on registered occupancy, so a pop from a full queue does not reopen it until the next cycle.
  assign a_req    = a_valid && (a_wr != '0);
  assign in_force = (state == ST_FORCE);
  assign a_grant  = a_req && !in_force;
  assign b_grant  = !empty && (!a_req || in_force);
  assign b_ready  = !full;
  assign push     = b_valid && b_ready && (b_wr != '0);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_wr       (b_wr),
    .push_wd       (b_wd),
    .pop           (b_grant),
    .kill_en       (a_grant),
    .kill_wr       (a_wr),
    .head_wr       (head_wr),
    .head_wd       (head_wd),
    .head_kill     (head_kill),
    .full          (full),
    .empty         (empty),
    .occupied_next (occupied_next),
    .pend_mask     (pend_mask)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wr = '0;
    rf_wd = '0;
    if (a_grant) begin
      rf_we = 1'b1;
      rf_wr = a_wr;
      rf_wd = a_wd;
    end else if (b_grant) begin
      rf_we = !head_kill;
      rf_wr = head_wr;
      rf_wd = head_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (in_force && a_req) err_drop <= 1'b1;
      case (state)
        ST_IDLE: begin
          starve_cnt <= '0;
          state      <= occupied_next ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          if (b_grant) begin
            starve_cnt <= '0;
            state      <= occupied_next ? ST_WAIT : ST_IDLE;
          end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
            starve_cnt <= '0;
            state      <= ST_FORCE;
            wb_stall   <= 1'b1;
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_FORCE: begin
          starve_cnt <= '0;
          state      <= occupied_next ? ST_WAIT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bgrant <= '0;
      stat_stall  <= '0;
    end else begin
      if (b_grant && stat_bgrant != '1) stat_bgrant <= stat_bgrant + 1'b1;
      if (in_force && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_wr = '0;
  logic [31:0] a_wd = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_wr = '0;
  logic [31:0] b_wd = '0;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        wb_stall;
  logic [31:0] pend_mask;
  logic        err_drop;
  logic [1:0]  dbg_state;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_bgrant, stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        kill;
  } ent_t;
  ent_t exp_q[$];
  bit   m_force;
  int   m_wait;
  bit   m_err;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wr(a_wr), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_wd(b_wd),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .wb_stall(wb_stall), .pend_mask(pend_mask), .err_drop(err_drop),
    .dbg_state(dbg_state)
`ifdef RF_ARB_STATS_EN
    , .stat_bgrant(stat_bgrant), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic [4:0] awr, input logic [31:0] awd,
                       input logic bv, input logic [4:0] bwr, input logic [31:0] bwd);
    @(negedge clk);
    a_valid = av; a_wr = awr; a_wd = awd;
    b_valid = bv; b_wr = bwr; b_wd = bwd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0; a_wr = '0; a_wd = '0;
    b_valid = 1'b0; b_wr = '0; b_wd = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %0b want 1", b_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got %0b want 0", wb_stall); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend_mask got %h want 0", pend_mask); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop got %0b want 0", err_drop); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_a_only();
    do_reset();
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL a_only_we got %0b want 1", rf_we); end
    checks++; if (rf_wr !== 5'd3) begin errors++; $display("FAIL a_only_wr got %0d want 3", rf_wr); end
    checks++; if (rf_wd !== 32'h11) begin errors++; $display("FAIL a_only_wd got %h want 11", rf_wd); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL a_only_b_ready got %0b want 1", b_ready); end
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL a_r0_idle got %0b want 0", rf_we); end
  endtask

  task automatic test_b_drain();
    do_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAB);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b_no_passthru got %0b want 0", rf_we); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL b_pend_before got %h want 0", pend_mask); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b_drain_we got %0b want 1", rf_we); end
    checks++; if (rf_wr !== 5'd5) begin errors++; $display("FAIL b_drain_wr got %0d want 5", rf_wr); end
    checks++; if (rf_wd !== 32'hAB) begin errors++; $display("FAIL b_drain_wd got %h want ab", rf_wd); end
    checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL b_pend_set got %h want 20", pend_mask); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL b_pend_clear got %h want 0", pend_mask); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b_after_drain got %0b want 0", rf_we); end
  endtask

  task automatic test_starve();
    do_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < STARVE_MAX; i++) begin
      drive(1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'h0);
      checks++; if (wb_stall !== 1'b0 || rf_wr !== 5'(10 + i)) begin
        errors++; $display("FAIL starve_busy%0d got stall=%0b wr=%0d want stall=0 wr=%0d", i, wb_stall, rf_wr, 10 + i);
      end
    end
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
    checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got %0b want 1", wb_stall); end
    checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd7 || rf_wd !== 32'h77) begin
      errors++; $display("FAIL starve_drain got we=%0b wr=%0d wd=%h want 1/7/77", rf_we, rf_wr, rf_wd);
    end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL starve_err_early got %0b want 0", err_drop); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL starve_err_drop got %0b want 1", err_drop); end
    checks++; if (wb_stall !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL starve_exit got stall=%0b we=%0b want 0/0", wb_stall, rf_we);
    end
  endtask

  task automatic test_waw();
    do_reset();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    checks++; if (pend_mask !== 32'h200) begin errors++; $display("FAIL waw_pend_before got %h want 200", pend_mask); end
    checks++; if (rf_wd !== 32'h99) begin errors++; $display("FAIL waw_a_wd got %h want 99", rf_wd); end
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL waw_pend_cleared got %h want 0", pend_mask); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL waw_killed_drain got %0b want 0", rf_we); end
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd9 || rf_wd !== 32'h2) begin
      errors++; $display("FAIL waw_same_cycle got we=%0b wr=%0d wd=%h want 1/9/2", rf_we, rf_wr, rf_wd);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(1 + i), 32'(100 + i));
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got %0b want 1", i, b_ready); end
    end
    drive(1'b1, 5'd30, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", b_ready); end
    checks++; if (pend_mask !== 32'h1E) begin errors++; $display("FAIL full_pend got %h want 1e", pend_mask); end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same got %0b want 0", b_ready); end
    checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd1) begin
      errors++; $display("FAIL full_pop_head got we=%0b wr=%0d want 1/1", rf_we, rf_wr);
    end
    drive(1'b1, 5'd31, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_pop_next got %0b want 1", b_ready); end
    checks++; if (pend_mask !== 32'h1C) begin errors++; $display("FAIL full_pend_after got %h want 1c", pend_mask); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(20 + i), 32'h0, 1'b1, 5'(1 + i), 32'(i));
    drive(1'b1, 5'd25, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (pend_mask !== 32'hE) begin errors++; $display("FAIL rstmid_pend_before got %h want e", pend_mask); end
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (pend_mask !== 32'h0 || b_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got pend=%h ready=%0b we=%0b want 0/1/0", pend_mask, b_ready, rf_we);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0) begin
        errors++; $display("FAIL rstmid_quiet%0d got we=%0b pend=%h want 0/0", i, rf_we, pend_mask);
      end
    end
  endtask

  task automatic test_random();
    logic        exp_we, exp_ready, a_req, granted_b, was_nonempty;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd, exp_pend;
    int          thresh;
    do_reset();
    exp_q.delete();
    m_force = 0; m_wait = 0; m_err = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      thresh = ((cyc / 50) % 2 == 0) ? 10 : 4;
      drive(1'($urandom_range(0, 9) < thresh), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      a_req = a_valid && (a_wr != 5'd0);
      exp_ready = (exp_q.size() < DEPTH);
      exp_pend = '0;
      foreach (exp_q[i]) if (!exp_q[i].kill) exp_pend[exp_q[i].wr] = 1'b1;
      exp_wr = '0; exp_wd = '0;
      if (a_req && !m_force) begin
        exp_we = 1'b1; exp_wr = a_wr; exp_wd = a_wd;
      end else if (exp_q.size() > 0) begin
        exp_we = !exp_q[0].kill; exp_wr = exp_q[0].wr; exp_wd = exp_q[0].wd;
      end else begin
        exp_we = 1'b0;
      end
      checks++; if (rf_we !== exp_we || (exp_we && (rf_wr !== exp_wr || rf_wd !== exp_wd))) begin
        errors++; $display("FAIL rnd_rf cyc%0d got %0b/%0d/%h want %0b/%0d/%h", cyc, rf_we, rf_wr, rf_wd, exp_we, exp_wr, exp_wd);
      end
      checks++; if (b_ready !== exp_ready || wb_stall !== m_force || err_drop !== m_err) begin
        errors++; $display("FAIL rnd_ctl cyc%0d got ready=%0b stall=%0b err=%0b want %0b/%0b/%0b",
                           cyc, b_ready, wb_stall, err_drop, exp_ready, m_force, m_err);
      end
      checks++; if (pend_mask !== exp_pend) begin
        errors++; $display("FAIL rnd_pend cyc%0d got %h want %h", cyc, pend_mask, exp_pend);
      end
      granted_b    = (exp_q.size() > 0) && (!a_req || m_force);
      was_nonempty = (exp_q.size() > 0);
      if (m_force && a_req) m_err = 1;
      if (a_req && !m_force) foreach (exp_q[i]) if (exp_q[i].wr == a_wr) exp_q[i].kill = 1'b1;
      if (granted_b) void'(exp_q.pop_front());
      if (b_valid && exp_ready && b_wr != 5'd0) exp_q.push_back('{wr: b_wr, wd: b_wd, kill: 1'b0});
      if (m_force) begin
        m_force = 0; m_wait = 0;
      end else if (granted_b) begin
        m_wait = 0;
      end else if (was_nonempty) begin
        m_wait++;
        if (m_wait == STARVE_MAX) begin m_force = 1; m_wait = 0; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_drain();
    test_starve();
    test_waw();
    test_full();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
